// File: rtl/if_pkg.sv
// Shared fetch-stage types and constants: FSM state encoding, bubble instruction, default reset PC.
`timescale 1ns/1ps
package if_pkg;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/instruction_fetch_stage_if.sv
// Instruction memory read port: one-cycle request with address, later response with data.
`timescale 1ns/1ps
interface instruction_fetch_stage_if;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemRvalid;
    logic [31:0] imemRdata;

    modport master (output imemReq, imemAddr, input imemRvalid, imemRdata);
    modport slave  (input imemReq, imemAddr, output imemRvalid, imemRdata);
endinterface

// File: rtl/program_counter.sv
// Fetch PC register: load (word-aligned) beats increment beats hold; +4 wraps modulo 2^32.
// Latency: new PC visible the cycle after load/incr; no backpressure, caller gates incr.
`timescale 1ns/1ps
module program_counter #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        i_load,
    input  logic [31:0] i_load_addr,
    input  logic        i_incr,
    output logic [31:0] o_pc
);
    logic [31:0] r_pc;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= if_pkg::word_align(i_load_addr);
        end else if (i_incr) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    assign o_pc = r_pc;
endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: one outstanding imem read, delivers {pc, instruction, valid} into the IF/ID register.
// Latency: >=2 cycles request-to-delivery; stall freezes outputs and buffers one response, redirect wins over stall.
`timescale 1ns/1ps
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC  = if_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = if_pkg::NOP_INSTR
) (
    input  logic                              clk,
    input  logic                              rstN,
    input  logic                              stall,
    input  logic                              redirect,
    input  logic [31:0]                       redirectPc,
    instruction_fetch_stage_if.master         imem,
    output logic [31:0]                       pcOut,
    output logic [31:0]                       instructionOut,
    output logic                              validOut
);
    if_pkg::fetch_state_t r_state;
    if_pkg::fetch_state_t w_state_nxt;

    logic [31:0] w_pc;
    logic        w_imem_req;
    logic        w_deliver;
    logic [31:0] w_deliver_dat;
    logic        w_capture;

    logic [31:0] r_hold_dat;
    logic [31:0] r_pc_out;
    logic [31:0] r_instr_out;
    logic        r_valid_out;

    program_counter #(.RESET_PC(RESET_PC)) u_pc (
        .clk         (clk),
        .rstN        (rstN),
        .i_load      (redirect),
        .i_load_addr (redirectPc),
        .i_incr      (w_deliver),
        .o_pc        (w_pc)
    );

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state <= if_pkg::IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_imem_req    = 1'b0;
        w_deliver     = 1'b0;
        w_deliver_dat = r_hold_dat;
        w_capture     = 1'b0;
        case (r_state)
            if_pkg::IDLE: begin
                if (!redirect) begin
                    w_imem_req  = 1'b1;
                    w_state_nxt = if_pkg::WAIT;
                end
            end
            if_pkg::WAIT: begin
                // A redirect with no response yet must still swallow the stale one.
                if (redirect) begin
                    w_state_nxt = imem.imemRvalid ? if_pkg::IDLE : if_pkg::DROP;
                end else if (imem.imemRvalid) begin
                    if (stall) begin
                        w_capture   = 1'b1;
                        w_state_nxt = if_pkg::HOLD;
                    end else begin
                        w_deliver     = 1'b1;
                        w_deliver_dat = imem.imemRdata;
                        w_state_nxt   = if_pkg::IDLE;
                    end
                end
            end
            if_pkg::HOLD: begin
                if (redirect) begin
                    w_state_nxt = if_pkg::IDLE;
                end else if (!stall) begin
                    w_deliver   = 1'b1;
                    w_state_nxt = if_pkg::IDLE;
                end
            end
            if_pkg::DROP: begin
                if (imem.imemRvalid) begin
                    w_state_nxt = if_pkg::IDLE;
                end
            end
            default: w_state_nxt = if_pkg::IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_hold_dat  <= 32'd0;
            r_pc_out    <= 32'd0;
            r_instr_out <= NOP_INSTR;
            r_valid_out <= 1'b0;
        end else begin
            if (w_capture) begin
                r_hold_dat <= imem.imemRdata;
            end
            // w_deliver already implies !redirect && !stall.
            if (redirect || !stall) begin
                if (w_deliver) begin
                    r_pc_out    <= w_pc;
                    r_instr_out <= w_deliver_dat;
                    r_valid_out <= 1'b1;
                end else begin
                    r_instr_out <= NOP_INSTR;
                    r_valid_out <= 1'b0;
                end
            end
        end
    end

    assign imem.imemReq   = w_imem_req & rstN;
    assign imem.imemAddr  = w_pc;
    assign pcOut          = r_pc_out;
    assign instructionOut = r_instr_out;
    assign validOut       = r_valid_out;
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed vector table, wrap-around sequence, randomized run against a reference model.
`timescale 1ns/1ps
module tb_instruction_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rstN, stall, redirect;
    logic [31:0] redirectPc;
    logic [31:0] pcOut, instructionOut;
    logic        validOut;

    logic        rstN2;
    logic [31:0] pcOut2, instructionOut2;
    logic        validOut2;

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch_stage_if ifc ();
    instruction_fetch_stage_if ifc2 ();

    instruction_fetch_stage dut (
        .clk(clk), .rstN(rstN), .stall(stall), .redirect(redirect), .redirectPc(redirectPc),
        .imem(ifc), .pcOut(pcOut), .instructionOut(instructionOut), .validOut(validOut)
    );

    instruction_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rstN(rstN2), .stall(1'b0), .redirect(1'b0), .redirectPc(32'd0),
        .imem(ifc2), .pcOut(pcOut2), .instructionOut(instructionOut2), .validOut(validOut2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rst_n, st, rd;
        logic [31:0] rpc;
        logic        rv;
        logic [31:0] rdat;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_vld;
        logic [31:0] e_pco, e_ins;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst_n, st, rd, input logic [31:0] rpc, input logic rv,
                       input logic [31:0] rdat, input logic e_req, input logic [31:0] e_addr,
                       input logic e_vld, input logic [31:0] e_pco, e_ins);
        vec_t v;
        v.rst_n = rst_n; v.st = st; v.rd = rd; v.rpc = rpc; v.rv = rv; v.rdat = rdat;
        v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_pco = e_pco; v.e_ins = e_ins;
        vecs.push_back(v);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // Reference model: pc, in-flight request (possibly stale), one buffered response, IF/ID outputs.
    logic [31:0] m_pc, m_bufd, o_pc, o_ins;
    logic        m_out, m_disc, m_buf, o_vld;

    initial begin
        logic        req_act, exp_req, st, rd, rv, deliver, mem_pend;
        logic [31:0] addr_act, rp, rdat, ddat, dpc, mem_addr;
        int          mem_cnt;

        rstN = 1'b0; stall = 1'b0; redirect = 1'b0; redirectPc = 32'd0;
        ifc.imemRvalid = 1'b0; ifc.imemRdata = 32'd0;
        rstN2 = 1'b0; ifc2.imemRvalid = 1'b0; ifc2.imemRdata = 32'd0;

        //   rst st rd rpc          rv rdat            req addr        vld pco           ins
        add(0, 0, 0, 32'h0,       0, 32'h0,          0, 32'h0,       0, 32'h0,       NOP);
        add(0, 0, 0, 32'h0,       0, 32'h0,          0, 32'h0,       0, 32'h0,       NOP);
        add(1, 0, 0, 32'h0,       0, 32'h0,          1, 32'h0,       0, 32'h0,       NOP);
        add(1, 0, 0, 32'h0,       1, 32'h1000_0000,  0, 32'h0,       1, 32'h0,       32'h1000_0000);
        add(1, 0, 0, 32'h0,       0, 32'h0,          1, 32'h4,       0, 32'h0,       NOP);
        add(1, 0, 0, 32'h0,       1, 32'h1000_0004,  0, 32'h0,       1, 32'h4,       32'h1000_0004);
        add(1, 0, 0, 32'h0,       0, 32'h0,          1, 32'h8,       0, 32'h4,       NOP);
        add(1, 0, 0, 32'h0,       1, 32'h1000_0008,  0, 32'h0,       1, 32'h8,       32'h1000_0008);
        add(1, 0, 0, 32'h0,       0, 32'h0,          1, 32'hC,       0, 32'h8,       NOP);
        add(1, 1, 0, 32'h0,       1, 32'h2000_000C,  0, 32'h0,       0, 32'h8,       NOP);
        add(1, 1, 0, 32'h0,       0, 32'h0,          0, 32'h0,       0, 32'h8,       NOP);
        add(1, 1, 0, 32'h0,       0, 32'h0,          0, 32'h0,       0, 32'h8,       NOP);
        add(1, 0, 0, 32'h0,       0, 32'h0,          0, 32'h0,       1, 32'hC,       32'h2000_000C);
        add(1, 0, 0, 32'h0,       0, 32'h0,          1, 32'h10,      0, 32'hC,       NOP);
        add(1, 0, 1, 32'h100,     0, 32'h0,          0, 32'h0,       0, 32'hC,       NOP);
        add(1, 0, 0, 32'h0,       0, 32'h0,          0, 32'h0,       0, 32'hC,       NOP);
        add(1, 0, 0, 32'h0,       1, 32'hDEAD_BEEF,  0, 32'h0,       0, 32'hC,       NOP);
        add(1, 0, 0, 32'h0,       0, 32'h0,          1, 32'h100,     0, 32'hC,       NOP);
        add(1, 0, 0, 32'h0,       1, 32'h3000_0100,  0, 32'h0,       1, 32'h100,     32'h3000_0100);
        add(1, 1, 0, 32'h0,       0, 32'h0,          1, 32'h104,     1, 32'h100,     32'h3000_0100);
        add(1, 1, 0, 32'h0,       1, 32'h3000_0104,  0, 32'h0,       1, 32'h100,     32'h3000_0100);
        add(1, 1, 1, 32'h200,     0, 32'h0,          0, 32'h0,       0, 32'h100,     NOP);
        add(1, 0, 0, 32'h0,       0, 32'h0,          1, 32'h200,     0, 32'h100,     NOP);
        add(1, 0, 0, 32'h0,       1, 32'h3000_0200,  0, 32'h0,       1, 32'h200,     32'h3000_0200);
        add(1, 0, 1, 32'h103,     0, 32'h0,          0, 32'h0,       0, 32'h200,     NOP);
        add(1, 0, 0, 32'h0,       0, 32'h0,          1, 32'h100,     0, 32'h200,     NOP);
        add(1, 0, 0, 32'h0,       1, 32'h4000_0100,  0, 32'h0,       1, 32'h100,     32'h4000_0100);
        add(1, 1, 0, 32'h0,       0, 32'h0,          1, 32'h104,     1, 32'h100,     32'h4000_0100);
        add(1, 0, 0, 32'h0,       1, 32'h4000_0104,  0, 32'h0,       1, 32'h104,     32'h4000_0104);
        add(1, 0, 0, 32'h0,       0, 32'h0,          1, 32'h108,     0, 32'h104,     NOP);
        add(0, 0, 0, 32'h0,       0, 32'h0,          0, 32'h0,       0, 32'h0,       NOP);
        add(1, 0, 0, 32'h0,       1, 32'h5555_5555,  1, 32'h0,       0, 32'h0,       NOP);
        add(1, 0, 0, 32'h0,       1, 32'h6000_0000,  0, 32'h0,       1, 32'h0,       32'h6000_0000);
        add(1, 0, 0, 32'h0,       0, 32'h0,          1, 32'h4,       0, 32'h0,       NOP);
        add(1, 0, 1, 32'h300,     0, 32'h0,          0, 32'h0,       0, 32'h0,       NOP);
        add(1, 1, 1, 32'h400,     0, 32'h0,          0, 32'h0,       0, 32'h0,       NOP);
        add(1, 0, 0, 32'h0,       1, 32'h7777_7777,  0, 32'h0,       0, 32'h0,       NOP);
        add(1, 0, 0, 32'h0,       0, 32'h0,          1, 32'h400,     0, 32'h0,       NOP);

        foreach (vecs[i]) begin
            @(negedge clk);
            rstN = vecs[i].rst_n; stall = vecs[i].st; redirect = vecs[i].rd;
            redirectPc = vecs[i].rpc; ifc.imemRvalid = vecs[i].rv; ifc.imemRdata = vecs[i].rdat;
            #1;
            chk($sformatf("vec%0d imemReq", i), {31'd0, ifc.imemReq}, {31'd0, vecs[i].e_req});
            if (vecs[i].e_req) chk($sformatf("vec%0d imemAddr", i), ifc.imemAddr, vecs[i].e_addr);
            @(posedge clk); #1;
            chk($sformatf("vec%0d validOut", i), {31'd0, validOut}, {31'd0, vecs[i].e_vld});
            chk($sformatf("vec%0d pcOut", i), pcOut, vecs[i].e_pco);
            chk($sformatf("vec%0d instructionOut", i), instructionOut, vecs[i].e_ins);
        end

        // PC wrap from the top of the address space on the second instance.
        @(negedge clk); rstN2 = 1'b0; #1;
        chk("wrap imemReq in reset", {31'd0, ifc2.imemReq}, 32'd0);
        @(posedge clk); #1;
        chk("wrap reset pcOut", pcOut2, 32'd0);
        chk("wrap reset instructionOut", instructionOut2, NOP);
        @(negedge clk); rstN2 = 1'b1; #1;
        chk("wrap first imemReq", {31'd0, ifc2.imemReq}, 32'd1);
        chk("wrap first imemAddr", ifc2.imemAddr, 32'hFFFF_FFFC);
        @(negedge clk); ifc2.imemRvalid = 1'b1; ifc2.imemRdata = 32'hABCD_0001;
        @(posedge clk); #1;
        chk("wrap first validOut", {31'd0, validOut2}, 32'd1);
        chk("wrap first pcOut", pcOut2, 32'hFFFF_FFFC);
        chk("wrap first instructionOut", instructionOut2, 32'hABCD_0001);
        @(negedge clk); ifc2.imemRvalid = 1'b0; #1;
        chk("wrap second imemReq", {31'd0, ifc2.imemReq}, 32'd1);
        chk("wrap second imemAddr", ifc2.imemAddr, 32'h0000_0000);
        @(negedge clk); ifc2.imemRvalid = 1'b1; ifc2.imemRdata = 32'hABCD_0002;
        @(posedge clk); #1;
        chk("wrap second pcOut", pcOut2, 32'h0000_0000);
        chk("wrap second instructionOut", instructionOut2, 32'hABCD_0002);
        @(negedge clk); ifc2.imemRvalid = 1'b0;

        // Randomized run against the reference model with a variable-latency memory.
        @(negedge clk); rstN = 1'b0; stall = 1'b0; redirect = 1'b0; ifc.imemRvalid = 1'b0;
        @(negedge clk); rstN = 1'b1;
        m_pc = 32'd0; m_out = 1'b0; m_disc = 1'b0; m_buf = 1'b0; m_bufd = 32'd0;
        o_pc = 32'd0; o_ins = NOP; o_vld = 1'b0;
        mem_pend = 1'b0; mem_cnt = 0; mem_addr = 32'd0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc != 0) @(negedge clk);
            st = ($urandom_range(0, 3) == 0);
            rd = ($urandom_range(0, 9) == 0);
            rp = ($urandom_range(0, 5) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7))) : $urandom;
            rdat = $urandom;
            if (mem_pend && mem_cnt == 0) begin
                rv = 1'b1; rdat = mem_word(mem_addr);
            end else begin
                rv = !mem_pend && ($urandom_range(0, 5) == 0);
            end
            stall = st; redirect = rd; redirectPc = rp; ifc.imemRvalid = rv; ifc.imemRdata = rdat;
            #1;
            req_act = ifc.imemReq; addr_act = ifc.imemAddr;
            exp_req = !m_out && !m_buf && !rd;
            chk("rand imemReq", {31'd0, req_act}, {31'd0, exp_req});
            if (exp_req) chk("rand imemAddr", addr_act, m_pc);
            @(posedge clk); #1;

            deliver = 1'b0; ddat = 32'd0; dpc = m_pc;
            if (rd) begin
                m_pc = rp & ~32'h3;
                m_buf = 1'b0;
                if (m_out) begin
                    if (rv) begin m_out = 1'b0; m_disc = 1'b0; end
                    else m_disc = 1'b1;
                end
            end else begin
                if (m_out && rv) begin
                    m_out = 1'b0;
                    if (m_disc) m_disc = 1'b0;
                    else if (st) begin m_buf = 1'b1; m_bufd = rdat; end
                    else begin deliver = 1'b1; ddat = rdat; end
                end else if (m_buf && !st) begin
                    deliver = 1'b1; ddat = m_bufd; m_buf = 1'b0;
                end
                if (exp_req) begin m_out = 1'b1; m_disc = 1'b0; end
                if (deliver) m_pc = m_pc + 32'd4;
            end
            if (rd) begin
                o_ins = NOP; o_vld = 1'b0;
            end else if (!st) begin
                if (deliver) begin o_pc = dpc; o_ins = ddat; o_vld = 1'b1; end
                else begin o_ins = NOP; o_vld = 1'b0; end
            end
            chk("rand validOut", {31'd0, validOut}, {31'd0, o_vld});
            chk("rand pcOut", pcOut, o_pc);
            chk("rand instructionOut", instructionOut, o_ins);

            if (mem_pend && rv) mem_pend = 1'b0;
            else if (mem_pend) mem_cnt--;
            if (req_act) begin
                mem_pend = 1'b1; mem_addr = addr_act; mem_cnt = $urandom_range(0, 2);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_stage.md
INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0).
REQ-003 clk  input  1  single clock, all state updates on its rising edge.
REQ-004 rstN  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 stall  input  1  downstream IF/ID cannot accept; hold outputs and PC.
REQ-006 redirect  input  1  branch/jump taken or flush; fetch restarts at redirectPc.
REQ-007 redirectPc  input  32  redirect target byte address.
REQ-008 imemReq  output  1  one-cycle instruction memory read request.
REQ-009 imemAddr  output  32  word-aligned read address, valid while imemReq=1.
REQ-010 imemRvalid  input  1  read data valid, at least 1 cycle after imemReq.
REQ-011 imemRdata  input  32  read data, valid when imemRvalid=1.
REQ-012 pcOut  output  32  PC of delivered instruction, to IF/ID register pcIn.
REQ-013 instructionOut  output  32  delivered instruction, to IF/ID instructionIn.
REQ-014 validOut  output  1  1 = instructionOut is a real fetched instruction.

Function
REQ-015 State machine SHALL have states IDLE, WAIT, HOLD, DROP; at most one memory request outstanding.
REQ-016 IDLE: imemReq=1, imemAddr=pc; next state WAIT unconditionally, unless redirect=1, in which case no request is issued, pc<=redirectPc and state stays IDLE.
REQ-017 WAIT, imemRvalid=1, redirect=0, stall=0: pcOut<=pc, instructionOut<=imemRdata, validOut<=1, pc<=pc+4, next IDLE.
REQ-018 WAIT, imemRvalid=1, redirect=0, stall=1: imemRdata captured in hold register, outputs unchanged, next HOLD.
REQ-019 WAIT, redirect=1: pc<=redirectPc; next IDLE if imemRvalid=1 (response discarded), else DROP.
REQ-020 DROP: imemRvalid response SHALL be discarded, next IDLE; redirect in DROP updates pc<=redirectPc and stays DROP until the response.
REQ-021 HOLD, stall=0, redirect=0: deliver hold register as in REQ-017, next IDLE.
REQ-022 HOLD, redirect=1: hold register discarded, pc<=redirectPc, next IDLE.
REQ-023 redirect SHALL take priority over stall in every state.
REQ-024 Any cycle with stall=1 and redirect=0 SHALL leave pcOut, instructionOut, validOut unchanged.
REQ-025 Any cycle with stall=0 that delivers no instruction (including all redirect cycles) SHALL set instructionOut<=NOP_INSTR, validOut<=0, pcOut unchanged.
REQ-026 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-027 redirectPc[1:0] SHALL be forced to 2'b00 when loaded into pc.
REQ-028 imemRvalid outside WAIT/DROP SHALL be ignored.

Reset
REQ-029 rstN=0 at a rising edge: pc<=RESET_PC, state<=IDLE, pcOut<=0, instructionOut<=NOP_INSTR, validOut<=0, hold register cleared; imemReq=0 while rstN=0.
REQ-030 Reset mid-request SHALL abandon the outstanding request; the environment resets the memory in the same cycle.

Structure
REQ-031 Shared package if_pkg SHALL hold the state enum, NOP_INSTR, and the default RESET_PC.
REQ-032 PC register and next-PC mux SHALL be a sub-module program_counter (load, increment, hold); FSM and output register stay in instruction_fetch_stage.

Verification
REQ-033 Reset then 1-cycle memory, no stall: imemAddr sequence 0x0,0x4,0x8; validOut=1 with pcOut 0x0,0x4,0x8 and matching data.
REQ-034 stall=1 for 3 cycles while response arrives: outputs frozen, state HOLD; stall release -> buffered instruction delivered once, next request to pc+4.
REQ-035 redirect to 0x100 while in WAIT, response 2 cycles later: response dropped, validOut=0, next imemAddr=0x100.
REQ-036 redirect=1 and stall=1 same cycle in HOLD: validOut=0, instructionOut=0x0000_0013, next imemAddr=redirectPc.
REQ-037 RESET_PC=32'hFFFF_FFFC: first fetch 0xFFFF_FFFC, second fetch 0x0000_0000.
REQ-038 redirectPc=0x0000_0103: next imemAddr=0x0000_0100.
